gmii_tx_ram_reader: RTL and testbench

Consumer for the shared 16-bit packet RAM: reads host-written frames from the RAM's port B and streams them onto the GMII transmit interface. Frames sit in a word-addressed ring as a length header followed by payload. The block adds preamble/SFD and enforces inter-frame gap. Its rd_ptr output returns consumed space to the producer.

---
 rtl/ethpipe_tx_pkg.sv | 21 ++
 rtl/gmii_tx_ram_reader.sv | 109 ++++++++++
 tb/tb_gmii_tx_ram_reader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ethpipe_tx_pkg.sv
// Shared definitions for the GMII transmit path: state encoding, framing bytes
// and default frame-length / gap limits.
package ethpipe_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_HDR_WAIT,
    ST_PRE,
    ST_DATA,
    ST_IFG
  } tx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  localparam int DEF_MIN_LEN    = 64;
  localparam int DEF_MAX_LEN    = 1518;
  localparam int DEF_IFG_CYCLES = 12;

endpackage

// File: rtl/gmii_tx_ram_reader.sv
// Pulls length-prefixed frames out of the packet-RAM ring (port B) and drives
// them onto GMII with preamble/SFD and a fixed inter-frame gap.
module gmii_tx_ram_reader
  import ethpipe_tx_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int MIN_LEN    = DEF_MIN_LEN,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int IFG_CYCLES = DEF_IFG_CYCLES
) (
  input  logic              gmii_tx_clk,
  input  logic              sys_rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ce,
  input  logic [15:0]       ram_q,
  output logic              gmii_tx_en,
  output logic [7:0]        gmii_txd,
  output logic              busy,
  output logic              tx_done,
  output logic              err_len
);

  tx_state_e         state, state_n;
  logic [15:0]       cnt;
  logic [15:0]       len_q;
  logic [15:0]       hold;
  logic              len_ok;
  logic              last_byte;
  logic [16:0]       len_rnd;
  logic [ADDR_W-1:0] next_hdr;

  assign len_ok    = (ram_q >= 16'(MIN_LEN)) && (ram_q <= 16'(MAX_LEN));
  assign last_byte = (state == ST_DATA) && (cnt == 16'(len_q - 16'd1));
  assign len_rnd   = {1'b0, len_q} + 17'd1;
  assign next_hdr  = rd_ptr + ADDR_W'(1) + ADDR_W'(len_rnd[16:1]);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:     if (enable && (rd_ptr != wr_ptr)) state_n = ST_HDR;
      ST_HDR:      state_n = ST_HDR_WAIT;
      ST_HDR_WAIT: state_n = len_ok ? ST_PRE : ST_IDLE;
      ST_PRE:      if (cnt == 16'd7) state_n = ST_DATA;
      ST_DATA:     if (last_byte) state_n = ST_IFG;
      ST_IFG:      if (cnt == 16'(IFG_CYCLES - 1)) state_n = ST_IDLE;
      default:     state_n = ST_IDLE;
    endcase
  end

  // Port B runs one word ahead: an address issued at edge E is latched into
  // hold at edge E+2, always on the cycle that emits an odd byte (or the SFD).
  always_ff @(posedge gmii_tx_clk) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      len_q      <= '0;
      hold       <= '0;
      rd_ptr     <= '0;
      ram_addr   <= '0;
      ram_ce     <= 1'b0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
      tx_done    <= 1'b0;
      err_len    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= (state_n != state) ? 16'd0 : cnt + 16'd1;
      ram_ce     <= (state_n != ST_IDLE) && (state_n != ST_IFG);
      gmii_tx_en <= 1'b0;
      gmii_txd   <= '0;
      tx_done    <= 1'b0;
      err_len    <= 1'b0;
      case (state)
        ST_IDLE: if (state_n == ST_HDR) ram_addr <= rd_ptr;
        ST_HDR_WAIT: begin
          len_q <= ram_q;
          if (!len_ok) begin
            err_len <= 1'b1;
            rd_ptr  <= wr_ptr;
          end
        end
        ST_PRE: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= (cnt == 16'd7) ? SFD_BYTE : PREAMBLE_BYTE;
          if (cnt == 16'd5 || cnt == 16'd7) ram_addr <= ram_addr + ADDR_W'(1);
          if (cnt == 16'd7) hold <= ram_q;
        end
        ST_DATA: begin
          gmii_tx_en <= 1'b1;
          gmii_txd   <= cnt[0] ? hold[15:8] : hold[7:0];
          if (cnt[0]) begin
            ram_addr <= ram_addr + ADDR_W'(1);
            hold     <= ram_q;
          end
          if (last_byte) begin
            tx_done <= 1'b1;
            rd_ptr  <= next_hdr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_tx_ram_reader.sv
// Directed bench: a behavioural port-B RAM feeds the reader; a negedge monitor
// captures the GMII stream and pulse counts for the directed checks below.
module tb_gmii_tx_ram_reader;

  logic        gmii_tx_clk = 1'b0;
  logic        sys_rst_n   = 1'b0;
  logic        enable      = 1'b0;
  logic [15:0] wr_ptr      = '0;
  logic [15:0] rd_ptr, ram_addr;
  logic        ram_ce;
  logic [15:0] ram_q = '0;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        busy, tx_done, err_len;

  gmii_tx_ram_reader dut (
    .gmii_tx_clk (gmii_tx_clk),
    .sys_rst_n   (sys_rst_n),
    .enable      (enable),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .ram_addr    (ram_addr),
    .ram_ce      (ram_ce),
    .ram_q       (ram_q),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .busy        (busy),
    .tx_done     (tx_done),
    .err_len     (err_len)
  );

  always #5 gmii_tx_clk = ~gmii_tx_clk;

  logic [15:0] mem [0:65535];
  always @(posedge gmii_tx_clk) if (ram_ce) ram_q <= mem[ram_addr];

  int checks = 0;
  int failures = 0;

  logic [7:0] cap[$];
  logic [7:0] expq[$];
  int run_len, last_run, low_run, last_gap, done_cnt, err_cnt;
  bit prev_en, seen_high;

  always @(negedge gmii_tx_clk) begin
    if (gmii_tx_en) begin
      cap.push_back(gmii_txd);
      if (!prev_en) begin
        if (seen_high) last_gap = low_run;
        seen_high = 1'b1;
        low_run = 0;
      end
      run_len++;
    end else begin
      if (prev_en) begin
        last_run = run_len;
        run_len = 0;
      end
      low_run++;
    end
    prev_en = gmii_tx_en;
    if (tx_done) done_cnt++;
    if (err_len) err_cnt++;
  end

  task automatic clr();
    cap.delete(); expq.delete();
    run_len = 0; last_run = 0; low_run = 0; last_gap = -1;
    done_cnt = 0; err_cnt = 0; prev_en = 1'b0; seen_high = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge gmii_tx_clk); #1; end
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
  endtask

  // Header at h, byte i = base+i; odd tail byte leaves 0xEE in the high lane.
  task automatic fill(input logic [15:0] h, input int len, input int base);
    logic [15:0] a;
    mem[h] = 16'(len);
    for (int k = 0; k < (len + 1) / 2; k++) begin
      a = h + 16'd1 + 16'(k);
      mem[a] = 16'hEEEE;
    end
    for (int i = 0; i < len; i++) begin
      a = h + 16'd1 + 16'(i >> 1);
      if (i[0]) mem[a][15:8] = 8'(base + i);
      else      mem[a][7:0]  = 8'(base + i);
    end
  endtask

  task automatic exp_frame(input int len, input int base);
    for (int i = 0; i < 7; i++) expq.push_back(8'h55);
    expq.push_back(8'hD5);
    for (int i = 0; i < len; i++) expq.push_back(8'(base + i));
  endtask

  function automatic int seq_err();
    int e = (cap.size() == expq.size()) ? 0 : 1;
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      if (cap[i] !== expq[i]) e++;
    return e;
  endfunction

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < 400) begin tick(1); n++; end
    chk(tag, 32'(done_cnt >= target), 1);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    clr();
    tick(3);
    // reset values
    chk("rst_rd_ptr", 32'(rd_ptr), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_ram_ce", 32'(ram_ce), 0);
    chk("rst_tx_en", 32'(gmii_tx_en), 0);
    chk("rst_txd", 32'(gmii_txd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_tx_done", 32'(tx_done), 0);
    chk("rst_err_len", 32'(err_len), 0);
    sys_rst_n = 1'b1;
    tick(1);

    // 64-byte frame at word 0, start latency
    clr();
    fill(16'h0000, 64, 0);
    exp_frame(64, 0);
    wr_ptr = 16'h0021; enable = 1'b1;
    tick(1);
    chk("lat_busy_e0", 32'(busy), 1);
    tick(2);
    chk("lat_txen_e2", 32'(gmii_tx_en), 0);
    tick(1);
    chk("lat_txen_e3", 32'(gmii_tx_en), 1);
    chk("lat_txd_e3", 32'(gmii_txd), 32'h55);
    wait_done("f64_timeout", 1);
    tick(20);
    chk("f64_seq", 32'(seq_err()), 0);
    chk("f64_run", 32'(last_run), 72);
    chk("f64_done", 32'(done_cnt), 1);
    chk("f64_rd_ptr", 32'(rd_ptr), 32'h21);
    chk("f64_idle", 32'(busy), 0);

    // odd length 65 at word 0
    enable = 1'b0; wr_ptr = '0;
    do_reset();
    clr();
    fill(16'h0000, 65, 0);
    exp_frame(65, 0);
    wr_ptr = 16'h0022; enable = 1'b1;
    wait_done("f65_timeout", 1);
    tick(20);
    chk("f65_seq", 32'(seq_err()), 0);
    chk("f65_last_byte", 32'(cap.size() == 73 ? cap[72] : 8'hXX), 32'h40);
    chk("f65_run", 32'(last_run), 73);
    chk("f65_rd_ptr", 32'(rd_ptr), 32'h22);

    // illegal lengths (below min, above max) flush to wr_ptr
    enable = 1'b0; wr_ptr = '0;
    do_reset();
    clr();
    mem[16'h0000] = 16'h0010;
    wr_ptr = 16'h0100; enable = 1'b1;
    tick(10);
    chk("ill_err_cnt", 32'(err_cnt), 1);
    chk("ill_no_tx", 32'(cap.size()), 0);
    chk("ill_rd_ptr", 32'(rd_ptr), 32'h0100);
    chk("ill_busy", 32'(busy), 0);
    mem[16'h0100] = 16'd1519;
    wr_ptr = 16'hFFF0;
    tick(10);
    chk("max_err_cnt", 32'(err_cnt), 2);
    chk("max_no_tx", 32'(cap.size()), 0);
    chk("max_rd_ptr", 32'(rd_ptr), 32'hFFF0);

    // frame straddling the top of the ring
    clr();
    fill(16'hFFF0, 64, 8'h80);
    exp_frame(64, 8'h80);
    wr_ptr = 16'h0011;
    wait_done("wrap_timeout", 1);
    tick(20);
    chk("wrap_seq", 32'(seq_err()), 0);
    chk("wrap_run", 32'(last_run), 72);
    chk("wrap_rd_ptr", 32'(rd_ptr), 32'h0011);

    // two back-to-back frames
    enable = 1'b0; wr_ptr = '0;
    do_reset();
    clr();
    fill(16'h0000, 64, 0);
    fill(16'h0021, 64, 8'h40);
    exp_frame(64, 0);
    exp_frame(64, 8'h40);
    wr_ptr = 16'h0042; enable = 1'b1;
    wait_done("b2b_timeout", 2);
    tick(20);
    chk("b2b_gap", 32'(last_gap), 15);
    chk("b2b_done", 32'(done_cnt), 2);
    chk("b2b_seq", 32'(seq_err()), 0);
    chk("b2b_rd_ptr", 32'(rd_ptr), 32'h42);

    // enable low holds off a pending frame; reset mid-frame truncates
    enable = 1'b0; wr_ptr = '0;
    do_reset();
    clr();
    wr_ptr = 16'h0042;
    tick(10);
    chk("en0_busy", 32'(busy), 0);
    chk("en0_no_tx", 32'(cap.size()), 0);
    enable = 1'b1;
    wait_done("rst_frame1_timeout", 1);
    chk("rst_mid_rd_ptr_pre", 32'(rd_ptr), 32'h21);
    tick(30);
    chk("rst_mid_in_frame", 32'(gmii_tx_en), 1);
    sys_rst_n = 1'b0; wr_ptr = '0;
    tick(1);
    chk("rst_mid_tx_en", 32'(gmii_tx_en), 0);
    chk("rst_mid_rd_ptr", 32'(rd_ptr), 0);
    chk("rst_mid_busy", 32'(busy), 0);
    sys_rst_n = 1'b1;
    tick(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
